// File: rtl/demux_rr.sv
// 1:2 receive-side demultiplexer with a small FIFO per channel; round-robin routing by default.
// Define DEMUX_ID_ROUTE_EN to route each word by data_in[7] instead of the alternating selector.
module demux_rr #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic [7:0] data_out_0,
  output logic       valid_out_0,
  input  logic       ready_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_1,
  input  logic       ready_1,
  output logic       full_0,
  output logic       full_1
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic          sel_q, sel_d;
  logic [7:0]    mem_q    [2][DEPTH];
  logic [AW-1:0] wr_ptr_q [2];
  logic [AW-1:0] wr_ptr_d [2];
  logic [AW-1:0] rd_ptr_q [2];
  logic [AW-1:0] rd_ptr_d [2];
  logic [AW:0]   cnt_q    [2];
  logic [AW:0]   cnt_d    [2];

  logic       tgt;
  logic       accept;
  logic [1:0] push, pop, full, nonempty, rdy;

  assign rdy = {ready_1, ready_0};

  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]     = (cnt_q[c] == CNT_FULL);
      nonempty[c] = (cnt_q[c] != '0);
    end
  end

`ifdef DEMUX_ID_ROUTE_EN
  assign tgt = data_in[7];
`else
  assign tgt = sel_q;
`endif

  // Stall decision uses the registered count only; a same-cycle pop never frees the slot.
  assign ready_in = ~full[tgt];
  assign accept   = valid_in & ready_in;

  always_comb begin
    push  = '0;
    pop   = '0;
    sel_d = sel_q;
    for (int c = 0; c < 2; c++) begin
      push[c]     = accept & (tgt == 1'(c));
      pop[c]      = nonempty[c] & rdy[c];
      wr_ptr_d[c] = wr_ptr_q[c] + AW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop[c]);
      cnt_d[c]    = cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
    end
`ifndef DEMUX_ID_ROUTE_EN
    if (accept) sel_d = ~sel_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= 8'h00;
      end
    end else begin
      sel_q <= sel_d;
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
        if (push[c]) mem_q[c][wr_ptr_q[c]] <= data_in;
      end
    end
  end

  assign data_out_0  = mem_q[0][rd_ptr_q[0]];
  assign data_out_1  = mem_q[1][rd_ptr_q[1]];
  assign valid_out_0 = nonempty[0];
  assign valid_out_1 = nonempty[1];
  assign full_0      = full[0];
  assign full_1      = full[1];

endmodule

// File: tb/tb_demux_rr.sv
// Randomized and directed bench for demux_rr against a queue-based reference model.
// Honours DEMUX_ID_ROUTE_EN the same way the design does.
module tb_demux_rr;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1;
  logic       ready_0 = 1'b0, ready_1 = 1'b0;
  logic       full_0, full_1;

  demux_rr #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out_0(data_out_0), .valid_out_0(valid_out_0), .ready_0(ready_0),
    .data_out_1(data_out_1), .valid_out_1(valid_out_1), .ready_1(ready_1),
    .full_0(full_0), .full_1(full_1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference state: one queue per channel plus the next round-robin target
  logic [7:0] q0[$], q1[$];
  logic [7:0] log0[$];
  bit         rr_next = 1'b0;
  bit         armed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit route(input logic [7:0] d);
`ifdef DEMUX_ID_ROUTE_EN
    return d[7];
`else
    return rr_next;
`endif
  endfunction

  task automatic step(input logic rst, input logic v, input logic [7:0] d,
                      input logic r0, input logic r1);
    bit t, acc;
    @(negedge clk);
    reset = rst; valid_in = v; data_in = d; ready_0 = r0; ready_1 = r1;
    #1;
    t = route(d);
    if (armed) begin
      check("ready_in", ready_in, (t ? q1.size() : q0.size()) < DEPTH);
      check("valid_out_0", valid_out_0, q0.size() != 0);
      check("valid_out_1", valid_out_1, q1.size() != 0);
      check("full_0", full_0, q0.size() == DEPTH);
      check("full_1", full_1, q1.size() == DEPTH);
      if (q0.size() != 0) check("data_out_0", data_out_0, q0[0]);
      if (q1.size() != 0) check("data_out_1", data_out_1, q1[0]);
    end
    if (rst) begin
      q0.delete(); q1.delete(); rr_next = 1'b0;
    end else begin
      acc = v && ((t ? q1.size() : q0.size()) < DEPTH);
      if (r0 && q0.size() != 0) begin log0.push_back(data_out_0); void'(q0.pop_front()); end
      if (r1 && q1.size() != 0) void'(q1.pop_front());
      if (acc) begin
        if (t) q1.push_back(d); else q0.push_back(d);
`ifndef DEMUX_ID_ROUTE_EN
        rr_next = ~rr_next;
`endif
      end
    end
    armed = 1'b1;
  endtask

  // word i with bit7 = i[0]: alternates channels in both routing modes
  function automatic logic [7:0] word(input int i);
    logic [7:0] w;
    w = 8'(i);
    w[7] = w[0];
    return w;
  endfunction

  initial begin
    // T1: reset with valid_in asserted
    step(1, 1, 8'hAA, 0, 0);
    step(1, 1, 8'h55, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("rst_data_out_0", data_out_0, 8'h00);
    check("rst_data_out_1", data_out_1, 8'h00);

    // T2: split of four back-to-back words with consumers ready
    for (int i = 0; i < 4; i++) step(0, 1, word(i), 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 1);

    // T3/T4: fill both FIFOs, stall the ninth, then pop-at-full with push refused
    for (int i = 0; i < 9; i++) step(0, 1, word(8'h20 + i), 0, 0);
    check("t3_full_0", full_0, 1'b1);
    check("t3_full_1", full_1, 1'b1);
    check("t3_stall", ready_in, 1'b0);
    step(0, 1, word(8'h28), 1, 0);
    step(0, 1, word(8'h28), 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 1);

    // T5: pointer wrap over three fill/drain rounds of channel 0
    step(1, 0, 8'h00, 0, 0);
    log0.delete();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step(0, 1, word(r * 8 + i), 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 1);
    end
    check("t5_count", log0.size(), 12);
    for (int i = 0; i < 12 && i < log0.size(); i++) check("t5_order", log0[i], 8'(2 * i));

    // T6: reset with words buffered on both channels
    for (int i = 0; i < 4; i++) step(0, 1, word(8'h40 + i), 0, 0);
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h06, 0, 0);
    check("t6_valid_out_0", valid_out_0, 1'b0);
    check("t6_valid_out_1", valid_out_1, 1'b0);
    step(0, 0, 8'h00, 0, 0);
    check("t6_sel_restart", valid_out_0, 1'b1);
    step(1, 0, 8'h00, 0, 0);

`ifdef DEMUX_ID_ROUTE_EN
    step(0, 1, 8'h85, 0, 0);
    step(0, 1, 8'h05, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    check("id_ch1", data_out_1, 8'h85);
    check("id_ch0", data_out_0, 8'h05);
`endif

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++)
      step($urandom_range(63) == 0, $urandom_range(3) != 0, 8'($urandom),
           1'($urandom_range(1)), $urandom_range(2) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
